// File: rtl/ysyx_25020037_scoreboard.sv
// ysyx_25020037_scoreboard: per-GPR pending-write scoreboard and issue gate.
// Define YSYX_25020037_SB_PERF_EN to enable the stall_cycles counter.
module ysyx_25020037_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [3:0]  dec_rs1,
  input  logic [3:0]  dec_rs2,
  input  logic        dec_rs1_used,
  input  logic        dec_rs2_used,
  input  logic [3:0]  dec_rd,
  input  logic        dec_wen,
  input  logic        dec_jump,
  input  logic        dec_fence_i,
  input  logic        exu_ready,
  output logic        issue_valid,
  output logic        dec_ready,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rd,
  input  logic        br_done,
  input  logic        flush,
  output logic [15:0] busy,
  output logic        sb_err,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN,
    WAIT_BR,
    DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  pend_q [16];
  logic [1:0]  pend_d [16];
  logic        sb_err_q, sb_err_d;
  logic [15:0] busy_w;
  logic [15:0] inc_w;
  logic [15:0] dec_w;
  logic        any_pend;
  logic        hazard;
  logic        issue;
  logic        underflow;

  always_comb begin
    busy_w = '0;
    for (int i = 1; i < 16; i++) begin
      busy_w[i] = (pend_q[i] != 2'd0);
    end
  end

  assign any_pend = |busy_w;

  always_comb begin
    hazard = 1'b0;
    if (dec_rs1_used && dec_rs1 != 4'd0 && busy_w[dec_rs1])
      hazard = 1'b1;
    if (dec_rs2_used && dec_rs2 != 4'd0 && busy_w[dec_rs2])
      hazard = 1'b1;
    if (dec_wen && dec_rd != 4'd0 && pend_q[dec_rd] == 2'd3)
      hazard = 1'b1;
  end

  // rst_n gates issue so nothing leaks out while reset is held
  assign issue = rst_n & dec_valid & exu_ready & ~hazard & ~flush
               & (state_q == RUN) & ~(dec_fence_i & any_pend);

  assign issue_valid = issue;
  assign dec_ready   = issue;
  assign busy        = busy_w;
  assign sb_err      = sb_err_q;

  always_comb begin
    inc_w     = '0;
    dec_w     = '0;
    underflow = 1'b0;
    if (issue && dec_wen && dec_rd != 4'd0)
      inc_w = 16'd1 << dec_rd;
    if (wb_valid && wb_rd != 4'd0) begin
      if (busy_w[wb_rd]) dec_w = 16'd1 << wb_rd;
      else               underflow = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      pend_d[i] = pend_q[i];
      if (inc_w[i] && !dec_w[i])
        pend_d[i] = pend_q[i] + 2'd1;
      else if (dec_w[i] && !inc_w[i])
        pend_d[i] = pend_q[i] - 2'd1;
    end
    pend_d[0] = 2'd0;
  end

  assign sb_err_d = sb_err_q | underflow;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (issue && dec_jump)
          state_d = WAIT_BR;
        else if (dec_valid && dec_fence_i && any_pend)
          state_d = DRAIN;
      end
      WAIT_BR: if (br_done)   state_d = RUN;
      DRAIN:   if (!any_pend) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      sb_err_q <= 1'b0;
      for (int i = 0; i < 16; i++) pend_q[i] <= 2'd0;
    end else begin
      state_q  <= state_d;
      sb_err_q <= sb_err_d;
      for (int i = 0; i < 16; i++) pend_q[i] <= pend_d[i];
    end
  end

`ifdef YSYX_25020037_SB_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (dec_valid && exu_ready && !issue)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= 32'd0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/ysyx_25020037_scoreboard.md
YSYX_25020037_SCOREBOARD -- requirements
Module: ysyx_25020037_scoreboard

Interface
REQ-001 SHALL have clock: clk, input, 1, the only clock; all state updates on its rising edge.
REQ-002 SHALL have reset: rst_n, input, 1, asynchronous, active-low; asserting it clears all state immediately.
REQ-003 SHALL have dec_valid, input, 1: the decode stage offers an instruction.
REQ-004 SHALL have dec_rs1 and dec_rs2, input, 4 each: source register indices.
REQ-005 SHALL have dec_rs1_used and dec_rs2_used, input, 1 each: the source is actually read.
REQ-006 SHALL have dec_rd, input, 4, and dec_wen, input, 1: destination index and GPR write enable.
REQ-007 SHALL have dec_jump, input, 1 (jal/jalr/branch/ecall/mret), and dec_fence_i, input, 1.
REQ-008 SHALL have exu_ready, input, 1: the execute stage can accept an instruction.
REQ-009 SHALL have issue_valid, output, 1: the offered instruction is issued this cycle.
REQ-010 SHALL have dec_ready, output, 1: decode may hold/advance; equals issue_valid.
REQ-011 SHALL have wb_valid, input, 1, and wb_rd, input, 4: writeback retires one write to wb_rd.
REQ-012 SHALL have br_done, input, 1 (control transfer resolved, no redirect), and flush, input, 1 (dnpc redirect).
REQ-013 SHALL have busy, output, 16: bit i = register i has a pending write.
REQ-014 SHALL have sb_err, output, 1: sticky writeback-underflow flag.
REQ-015 SHALL have stall_cycles, output, 32: performance counter.

Function
REQ-016 SHALL keep a 2-bit pending counter pend[i] per register i = 1..15; register 0 is never tracked, busy[0] = 0.
REQ-017 SHALL define hazard = (rs1_used & rs1!=0 & pend[rs1]!=0) | (rs2_used & rs2!=0 & pend[rs2]!=0) | (dec_wen & rd!=0 & pend[rd]==3).
REQ-018 SHALL drive issue_valid = dec_valid & exu_ready & ~hazard & ~flush & state==RUN & ~(dec_fence_i & any pend!=0), combinationally, with zero-cycle latency.
REQ-019 SHALL, on issue with dec_wen & rd!=0, increment pend[rd] at the next edge.
REQ-020 SHALL, on wb_valid with wb_rd!=0 and pend[wb_rd]!=0, decrement pend[wb_rd].
REQ-021 SHALL leave a counter unchanged when an increment and a decrement hit the same register in the same cycle.
REQ-022 SHALL, on wb_valid to a register whose counter is 0, not change the counter and set sb_err; sb_err stays set until reset.
REQ-023 SHALL implement an FSM with states RUN, WAIT_BR, and DRAIN.
REQ-024 SHALL transition RUN -> WAIT_BR when an instruction with dec_jump issues; no issue occurs in WAIT_BR.
REQ-025 SHALL transition WAIT_BR -> RUN on br_done or flush.
REQ-026 SHALL transition RUN -> DRAIN when dec_valid & dec_fence_i and any counter is nonzero.
REQ-027 SHALL transition DRAIN -> RUN in the cycle after all counters read zero; the fence.i issues from RUN.
REQ-028 SHALL give flush priority over all other transitions, forcing the state to RUN next cycle.
REQ-029 SHALL suppress issue during the cycle flush is high.
REQ-030 SHALL NOT clear counters on flush, because already-issued instructions still write back.
REQ-031 SHALL let writebacks continue to decrement counters in every state.

Reset
REQ-032 SHALL, while rst_n=0, force state=RUN, all counters=0, sb_err=0, stall_cycles=0.
REQ-033 SHALL drive busy=0 and issue_valid=0 while rst_n=0.
REQ-034 SHALL, on a mid-operation reset, discard all pending counts; a post-reset writeback to a register with count 0 sets sb_err per REQ-022.

Configuration
REQ-035 SHALL use macro YSYX_25020037_SB_PERF_EN.
REQ-036 SHALL, when the macro is defined, increment stall_cycles (modulo 2^32, wrapping) each cycle that dec_valid & exu_ready & ~issue_valid.
REQ-037 SHALL, when the macro is undefined, keep the stall_cycles port but tie it to 0 with no counter logic.

Verification
REQ-038 SHALL cover RAW: issue addi x5 (wen, rd=5) -> busy[5]=1; next cycle offer add rs1=5 -> issue_valid=0 until wb_valid wb_rd=5, then issue_valid=1 the following cycle.
REQ-039 SHALL cover x0: offer rd=0 wen=1 followed by rs1=0 -> both issue back-to-back; busy stays 16'h0000.
REQ-040 SHALL cover same-cycle increment/decrement: pend[3]=1; issue rd=3 plus wb_rd=3 in the same cycle -> pend[3] stays 1, busy[3]=1.
REQ-041 SHALL cover saturation and underflow: three writes to x7 in flight, then a fourth with rd=7 -> stalled; wb_valid wb_rd=9 with pend[9]=0 -> sb_err=1 and stays set.
REQ-042 SHALL cover branch with flush: issue beq -> WAIT_BR, next offer blocked; flush=1 -> RUN next cycle with counters unchanged; br_done path also returns to RUN.
REQ-043 SHALL cover fence.i and the perf counter: fence.i with pend[2]=1 -> DRAIN; wb to x2 -> RUN, then fence.i issues; with PERF_EN, stall_cycles equals the number of blocked exu_ready cycles (for example 3).
